// File: rtl/period_meter_pkg.sv
// Shared constants and sizing helpers for the period meter and its edge detector.
package period_meter_pkg;

  localparam logic S_IDLE    = 1'b0;
  localparam logic S_MEASURE = 1'b1;

  // Cycles in the longest measurable period; 64-bit product avoids overflow at high clock rates.
  function automatic int unsigned f_max_cycles(input int unsigned clk_frq,
                                               input int unsigned max_period_ms);
    longint unsigned prod;
    prod = (64'(clk_frq) * 64'(max_period_ms)) / 64'd1000;
    return 32'(prod);
  endfunction

  function automatic int unsigned f_cnt_width(input int unsigned max_cycles);
    return 32'($clog2(64'(max_cycles) + 64'd1));
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous input followed by rise/fall edge detection.
module sync_edge_detect #(
  parameter int unsigned C_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [C_SYNC_STAGES-1:0] sync_q;
  logic [C_SYNC_STAGES-1:0] sync_d;
  logic                     prev_q;
  logic                     prev_d;

  always_comb begin
    sync_d = {sync_q[C_SYNC_STAGES-2:0], d};
    prev_d = sync_q[C_SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[C_SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures the rising-edge to rising-edge period of an asynchronous square wave in clk cycles.
// Optional high-time measurement is enabled by defining PERIOD_METER_DUTY_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter  int unsigned C_CLK_FRQ     = 100_000_000,
  parameter  int unsigned C_MAX_PERIOD  = 1000,
  parameter  int unsigned C_SYNC_STAGES = 2,
  localparam int unsigned C_MAX_CYCLES  = f_max_cycles(C_CLK_FRQ, C_MAX_PERIOD),
  localparam int unsigned C_CNT_WIDTH   = f_cnt_width(C_MAX_CYCLES)
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   sig_in,
  output logic [C_CNT_WIDTH-1:0] period,
  output logic                   valid,
  output logic                   timeout,
  output logic                   busy
`ifdef PERIOD_METER_DUTY_EN
  ,
  output logic [C_CNT_WIDTH-1:0] high_time
`endif
);

  localparam logic [C_CNT_WIDTH-1:0] C_CNT_MAX = C_CNT_WIDTH'(C_MAX_CYCLES);
  localparam logic [C_CNT_WIDTH-1:0] C_CNT_ONE = C_CNT_WIDTH'(1);

  logic rise;
  logic fall;
  logic sync_unused;

  sync_edge_detect #(
    .C_SYNC_STAGES(C_SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk (clk),
    .rstb(rstb),
    .d   (sig_in),
    .q   (sync_unused),
    .rise(rise),
    .fall(fall)
  );

  logic                   state_q,   state_d;
  logic [C_CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic [C_CNT_WIDTH-1:0] period_q,  period_d;
  logic                   valid_q,   valid_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q,    busy_d;

`ifdef PERIOD_METER_DUTY_EN
  logic [C_CNT_WIDTH-1:0] high_cnt_q,  high_cnt_d;
  logic                   high_fell_q, high_fell_d;
  logic [C_CNT_WIDTH-1:0] high_time_q, high_time_d;
`else
  logic fall_unused;
  assign fall_unused = fall;
`endif

  // Next-state: count between rises; the edge wins over a coincident timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
`ifdef PERIOD_METER_DUTY_EN
    high_cnt_d  = high_cnt_q;
    high_fell_d = high_fell_q;
    high_time_d = high_time_q;
`endif
    if (state_q == S_IDLE) begin
      if (rise) begin
        cnt_d   = C_CNT_ONE;
        state_d = S_MEASURE;
`ifdef PERIOD_METER_DUTY_EN
        high_fell_d = 1'b0;
`endif
      end
    end else begin
      if (rise) begin
        period_d  = cnt_q;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
        cnt_d     = C_CNT_ONE;
`ifdef PERIOD_METER_DUTY_EN
        high_time_d = high_fell_q ? high_cnt_q : cnt_q;
        high_fell_d = 1'b0;
`endif
      end else begin
`ifdef PERIOD_METER_DUTY_EN
        // cnt equals cycles since the rise, so it doubles as the high-phase length at the fall.
        if (fall) begin
          high_cnt_d  = cnt_q;
          high_fell_d = 1'b1;
        end
`endif
        if (cnt_q == C_CNT_MAX) begin
          timeout_d = 1'b1;
          period_d  = '0;
          state_d   = S_IDLE;
          cnt_d     = '0;
`ifdef PERIOD_METER_DUTY_EN
          high_time_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
    end
    busy_d = (state_d == S_MEASURE);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
      high_cnt_q  <= '0;
      high_fell_q <= 1'b0;
      high_time_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
`ifdef PERIOD_METER_DUTY_EN
      high_cnt_q  <= high_cnt_d;
      high_fell_q <= high_fell_d;
      high_time_q <= high_time_d;
`endif
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;
`ifdef PERIOD_METER_DUTY_EN
  assign high_time = high_time_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: event-time model checked every cycle plus directed literal checkpoints.
module tb_period_meter;

  localparam int unsigned C_CLK_FRQ     = 1_000_000;
  localparam int unsigned C_MAX_PERIOD  = 1;
  localparam int unsigned C_SYNC_STAGES = 2;
  localparam int          C_MAX         = 1000;
  localparam int          W             = 10;
  localparam int          S             = 2;

  logic         clk = 1'b0;
  logic         rstb;
  logic         sig_in;
  logic [W-1:0] period;
  logic         valid;
  logic         timeout;
  logic         busy;
`ifdef PERIOD_METER_DUTY_EN
  logic [W-1:0] high_time;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  period_meter #(
    .C_CLK_FRQ    (C_CLK_FRQ),
    .C_MAX_PERIOD (C_MAX_PERIOD),
    .C_SYNC_STAGES(C_SYNC_STAGES)
  ) dut (
    .clk    (clk),
    .rstb   (rstb),
    .sig_in (sig_in),
    .period (period),
    .valid  (valid),
    .timeout(timeout),
    .busy   (busy)
`ifdef PERIOD_METER_DUTY_EN
    ,
    .high_time(high_time)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the synchronised input lags sig_in by S samples; events are handled as rise/fall times.
  bit h [0:S];
  bit started = 1'b0;
  int n = 0;
  bit armed = 1'b0;
  int t_last = 0;
  int t_fall = 0;
  bit fall_seen = 1'b0;
  int exp_period = 0;
  bit exp_valid = 1'b0;
  bit exp_timeout = 1'b0;
  bit exp_busy = 1'b0;
  int exp_high = 0;

  always @(posedge clk) begin : model
    bit r;
    bit f;
    n++;
    if (!rstb) begin
      for (int i = 0; i <= S; i++) h[i] = 1'b0;
      armed = 1'b0; fall_seen = 1'b0; started = 1'b1;
      exp_period = 0; exp_valid = 1'b0; exp_timeout = 1'b0; exp_busy = 1'b0; exp_high = 0;
    end else begin
      r = h[S-1] & ~h[S];
      f = ~h[S-1] & h[S];
      for (int i = S; i > 0; i--) h[i] = h[i-1];
      h[0] = sig_in;
      exp_valid = 1'b0;
      if (r) begin
        if (armed) begin
          exp_period  = n - t_last;
          exp_valid   = 1'b1;
          exp_timeout = 1'b0;
          exp_high    = fall_seen ? (t_fall - t_last) : (n - t_last);
        end
        armed = 1'b1; t_last = n; fall_seen = 1'b0; exp_busy = 1'b1;
      end else if (armed && (n - t_last == C_MAX)) begin
        armed = 1'b0; exp_timeout = 1'b1; exp_period = 0; exp_busy = 1'b0; exp_high = 0;
      end else if (armed && f) begin
        t_fall = n; fall_seen = 1'b1;
      end
    end
  end

  int n_valid = 0;
  int last_period = -1;

  always @(negedge clk) begin
    if (started) begin
      chk("period", int'(period), exp_period);
      chk("valid", int'(valid), int'(exp_valid));
      chk("timeout", int'(timeout), int'(exp_timeout));
      chk("busy", int'(busy), int'(exp_busy));
`ifdef PERIOD_METER_DUTY_EN
      chk("high_time", int'(high_time), exp_high);
`endif
      if (valid) begin
        n_valid++;
        last_period = int'(period);
      end
    end
  end

  task automatic step(input logic v);
    sig_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int k);
    repeat (k) step(v);
  endtask

  task automatic wave(input int hi, input int lo, input int k);
    repeat (k) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  initial begin
    int base;
    rstb = 1'b0;
    sig_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_busy", int'(busy), 0);
    rstb = 1'b1;

    // steady 100-cycle wave, 50% duty
    base = n_valid;
    wave(50, 50, 5);
    chk("steady_count", n_valid - base, 4);
    chk("steady_period", last_period, 100);
    chk("steady_timeout", int'(timeout), 0);
    chk("steady_busy", int'(busy), 1);
`ifdef PERIOD_METER_DUTY_EN
    chk("steady_high", int'(high_time), 50);
`endif

    // period change 100 -> 37
    base = n_valid;
    wave(18, 19, 6);
    chk("change_count", n_valid - base, 6);
    chk("change_period", last_period, 37);
`ifdef PERIOD_METER_DUTY_EN
    chk("change_high", int'(high_time), 18);
`endif

    // held low -> timeout, then two rises 200 apart
    base = n_valid;
    hold(1'b0, 1100);
    chk("to_count", n_valid - base, 0);
    chk("to_timeout", int'(timeout), 1);
    chk("to_period", int'(period), 0);
    chk("to_busy", int'(busy), 0);
    wave(100, 100, 2);
    chk("rearm_count", n_valid - base, 1);
    chk("rearm_period", last_period, 200);
    chk("rearm_timeout", int'(timeout), 0);

    // boundary: 1000 apart measures, 1001 apart times out
    hold(1'b0, 1100);
    chk("bnd_idle_timeout", int'(timeout), 1);
    base = n_valid;
    wave(10, 990, 3);
    chk("bnd1000_count", n_valid - base, 2);
    chk("bnd1000_period", last_period, 1000);
    chk("bnd1000_timeout", int'(timeout), 0);
    wave(10, 991, 2);
    hold(1'b0, 1100);
    chk("bnd1001_count", n_valid - base, 3);
    chk("bnd1001_period", last_period, 1000);
    chk("bnd1001_timeout", int'(timeout), 1);

    // reset mid-measurement
    wave(50, 50, 2);
    hold(1'b1, 50);
    hold(1'b0, 20);
    rstb = 1'b0;
    step(1'b0);
    rstb = 1'b1;
    chk("midrst_period", int'(period), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_timeout", int'(timeout), 0);
    chk("midrst_busy", int'(busy), 0);
    base = n_valid;
    hold(1'b0, 30);
    wave(50, 50, 3);
    chk("postrst_count", n_valid - base, 2);
    chk("postrst_period", last_period, 100);
    chk("postrst_busy", int'(busy), 1);

    // toggling every cycle
    base = n_valid;
    wave(1, 1, 20);
    hold(1'b0, 5);
    chk("fast_count", n_valid - base, 20);
    chk("fast_period", last_period, 2);
`ifdef PERIOD_METER_DUTY_EN
    chk("fast_high", int'(high_time), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
